// File: rtl/axil_proc_pkg.sv
// Shared constants for the AXI-Lite processing register bank:
// response codes, register indices and the RESULT operating modes.
package axil_proc_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int REG_DIN     = 0;
  localparam int REG_RESULT  = 1;
  localparam int REG_CTRL    = 2;
  localparam int REG_OPERAND = 3;

  typedef enum logic [1:0] {
    MODE_INV  = 2'd0,
    MODE_ADD  = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_ROTL = 2'd3
  } mode_e;

endpackage

// File: rtl/axil_proc_alu.sv
// Combinational RESULT function: invert, wrapping add, xor or rotate-left
// of DIN, selected by MODE.
module axil_proc_alu
  import axil_proc_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic [DATA_WIDTH-1:0] OPERAND,
  input  mode_e                 MODE,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int SH_W = $clog2(DATA_WIDTH);
  localparam logic [SH_W:0] DW_L = (SH_W + 1)'(DATA_WIDTH);

  logic [SH_W-1:0] rot_amt;
  logic [SH_W:0]   rot_back;

  // A zero rotate shifts right by the full width, which yields 0 and leaves DIN intact.
  always_comb begin
    rot_amt  = OPERAND[SH_W-1:0];
    rot_back = DW_L - {1'b0, rot_amt};
    unique case (MODE)
      MODE_INV:  result = ~DIN;
      MODE_ADD:  result = DIN + OPERAND;
      MODE_XOR:  result = DIN ^ OPERAND;
      MODE_ROTL: result = (DIN << rot_amt) | (DIN >> rot_back);
      default:   result = ~DIN;
    endcase
  end

endmodule

// File: rtl/axil_regbank_proc.sv
// AXI-Lite slave register bank with a RESULT register recomputed from
// DIN/CTRL/OPERAND one cycle after any committed write to those registers.
module axil_regbank_proc
  import axil_proc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic [1:0]              BRESP,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic                    result_upd
);

  localparam int SW    = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] NREGS      = (ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [IDX_W-1:0]    I_DIN      = IDX_W'(REG_DIN);
  localparam logic [IDX_W-1:0]    I_RESULT   = IDX_W'(REG_RESULT);
  localparam logic [IDX_W-1:0]    I_CTRL     = IDX_W'(REG_CTRL);
  localparam logic [IDX_W-1:0]    I_OPERAND  = IDX_W'(REG_OPERAND);

  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [SW-1:0]         w_strb_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  res_pend;

  logic                  commit;
  logic                  wr_ok;
  logic                  wr_feeds_result;
  logic [IDX_W-1:0]      aw_idx;
  logic [IDX_W-1:0]      ar_idx;
  logic                  ar_in_range;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] wr_val;
  logic [DATA_WIDTH-1:0] alu_result;
  mode_e                 mode;

  // Handshakes: a transfer happens on the rising edge where VALID && READY;
  // VALID never depends on READY, and a slave output held VALID stays stable
  // (payload included) until the edge that completes its transfer.
  assign AWREADY = !aw_held && !BVALID;
  assign WREADY  = !w_held && !BVALID;
  assign ARREADY = !RVALID;

  assign commit          = aw_held && w_held;
  assign aw_idx          = aw_addr_q[IDX_W-1:0];
  assign ar_idx          = ARADDR[IDX_W-1:0];
  assign ar_in_range     = {1'b0, ARADDR} < NREGS;
  assign wr_ok           = ({1'b0, aw_addr_q} < NREGS) && (aw_idx != I_RESULT);
  assign wr_feeds_result = commit && wr_ok &&
                           (aw_idx == I_DIN || aw_idx == I_CTRL || aw_idx == I_OPERAND);
  assign mode            = mode_e'(regs[I_CTRL][1:0]);

  always_comb begin
    wr_merged = regs[aw_idx];
    for (int b = 0; b < SW; b++) begin
      if (w_strb_q[b]) wr_merged[b*8 +: 8] = w_data_q[b*8 +: 8];
    end
    // CTRL only implements MODE; the rest of the word is held at zero.
    if (aw_idx == I_CTRL) wr_val = {{(DATA_WIDTH-2){1'b0}}, wr_merged[1:0]};
    else                  wr_val = wr_merged;
  end

  axil_proc_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .DIN     (regs[I_DIN]),
    .OPERAND (regs[I_OPERAND]),
    .MODE    (mode),
    .result  (alu_result)
  );

  always_ff @(posedge clk or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      BVALID    <= 1'b0;
      BRESP     <= RESP_OKAY;
    end else begin
      if (AWVALID && AWREADY) begin
        aw_held   <= 1'b1;
        aw_addr_q <= AWADDR;
      end
      if (WVALID && WREADY) begin
        w_held   <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        BVALID  <= 1'b1;
        BRESP   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (BVALID && BREADY) begin
        BVALID <= 1'b0;
      end
    end
  end

  // A committed write never targets RESULT, so the two updates below never collide.
  always_ff @(posedge clk or negedge ARESETN) begin
    if (!ARESETN) begin
      regs       <= '{default: '0};
      res_pend   <= 1'b0;
      result_upd <= 1'b0;
    end else begin
      if (commit && wr_ok) regs[aw_idx] <= wr_val;
      if (res_pend) regs[I_RESULT] <= alu_result;
      res_pend   <= wr_feeds_result;
      result_upd <= res_pend;
    end
  end

  always_ff @(posedge clk or negedge ARESETN) begin
    if (!ARESETN) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
      RRESP  <= RESP_OKAY;
    end else if (ARVALID && ARREADY) begin
      RVALID <= 1'b1;
      RDATA  <= ar_in_range ? regs[ar_idx] : '0;
      RRESP  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (RVALID && RREADY) begin
      RVALID <= 1'b0;
    end
  end

endmodule

// File: doc/axil_regbank_proc.md
AXIL_REGBANK_PROC -- requirements
Module: axil_regbank_proc

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_WIDTH, 8: data bus width; 8, 16 or 32.
- NUM_REGS, 8: implemented word registers; power of 2, 4..16.
- ADDR_WIDTH, 4: word address width; must satisfy 2^ADDR_WIDTH >= NUM_REGS.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1: clock.
- ARESETN, in, 1: reset, asynchronous, active-low; clock clk.
- AWADDR, in, ADDR_WIDTH: write word address.
- AWVALID / AWREADY, in / out, 1: write-address handshake.
- WDATA, in, DATA_WIDTH: write data.
- WSTRB, in, DATA_WIDTH/8: byte strobes.
- WVALID / WREADY, in / out, 1: write-data handshake.
- BVALID / BREADY, out / in, 1: write-response handshake.
- BRESP, out, 2: write response.
- ARADDR, in, ADDR_WIDTH: read word address.
- ARVALID / ARREADY, in / out, 1: read-address handshake.
- RDATA, out, DATA_WIDTH: read data.
- RRESP, out, 2: read response.
- RVALID / RREADY, out / in, 1: read-data handshake.
- result_upd, out, 1: one-cycle pulse when RESULT changes.

Function
REQ-003 The register map SHALL be: 0 DIN (RW); 1 RESULT (RO); 2 CTRL (RW, bits [1:0] = MODE, other bits read 0); 3 OPERAND (RW); 4..NUM_REGS-1 scratch (RW).
REQ-004 The response codes SHALL be: OKAY = 2'b00, SLVERR = 2'b10.
REQ-005 The write response SHALL be SLVERR with no register change for an address >= NUM_REGS or address 1; all other writes SHALL return OKAY.
REQ-006 A read of an address >= NUM_REGS SHALL return RRESP=SLVERR and RDATA=0; all other reads SHALL return OKAY.
REQ-007 AW and W SHALL be accepted independently and in either order:
- AWREADY = !aw_held && !BVALID.
- WREADY = !w_held && !BVALID.
- Each handshake latches its address or data+strobe into its holding register.
REQ-008 When aw_held and w_held are both set, the next edge SHALL commit the write:
- Update only the bytes whose WSTRB bit is 1.
- Set BVALID=1 and clear both holds.
- Minimum latency is 1 cycle from the later of the two handshakes to BVALID.
REQ-009 BVALID and BRESP SHALL stay stable until the BVALID&&BREADY edge; while BVALID is high, no new AW or W SHALL be accepted.
REQ-010 RESULT SHALL be a register updated on the edge after any committed write to DIN, CTRL or OPERAND, with result_upd high for exactly that cycle.
REQ-011 RESULT SHALL be computed per MODE:
- 0: ~DIN.
- 1: (DIN + OPERAND) mod 2^DATA_WIDTH.
- 2: DIN ^ OPERAND.
- 3: DIN rotated left by OPERAND[log2(DATA_WIDTH)-1:0].
REQ-012 ARREADY SHALL equal !RVALID; an AR handshake at edge E SHALL register RDATA/RRESP and raise RVALID after E (1-cycle latency).
REQ-013 RVALID, RDATA and RRESP SHALL hold until the RVALID&&RREADY edge.
REQ-014 A read sampling at the same edge as a write commit or RESULT update SHALL return the pre-update value.
REQ-015 The read and write channels SHALL operate concurrently with no mutual stalling.

Reset
REQ-016 While ARESETN is low, the following SHALL be 0: BVALID, RVALID, RDATA, BRESP, RRESP, result_upd, all registers, holds and MODE.
REQ-017 After ARESETN deasserts, AWREADY, WREADY and ARREADY SHALL be 1.
REQ-018 Reset asserted mid-transaction SHALL discard held AW/W and pending B/R responses without committing.

Structure
REQ-019 Package axil_proc_pkg SHALL hold the RESP_OKAY/RESP_SLVERR constants, the register-index constants and the MODE enumeration.
REQ-020 A combinational sub-module axil_proc_alu (inputs DIN, OPERAND, MODE; output result) SHALL implement REQ-011; the handshake and register logic stays in the top module.

Verification
REQ-021 The bench SHALL cover these scenarios (DATA_WIDTH=8 and NUM_REGS=8 unless noted):
- Reset: all outputs match REQ-016; AWREADY=WREADY=ARREADY=1 one cycle after deassert.
- Write DIN=0x5A with MODE=0, then read addr 1 -> RDATA=0xA5, RRESP=OKAY; result_upd pulses once.
- MODE=1, OPERAND=0x0F via W-before-AW (W 3 cycles earlier), then DIN=0xF5 -> RESULT=0x04 (wrap).
- Write addr 1 -> BRESP=SLVERR, RESULT unchanged; read addr 12 -> RRESP=SLVERR, RDATA=0x00.
- DATA_WIDTH=16: write 0xBEEF to addr 4, then 0x1234 with WSTRB=2'b01 -> read 0xBE34; MODE=3, OPERAND=4, DIN=0x1234 -> RESULT=0x2341.
- Hold BREADY low 5 cycles -> BVALID/BRESP stable and AWREADY=0; assert ARESETN low mid-hold -> BVALID=0 and no pending write committed.
